// File: rtl/sobel_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +-------------------------------------------------------------------------+
// | sobel_pkg                                                                |
// | Shared state encoding and arithmetic helpers for the Sobel stream pipe.  |
// | Revision: 1.0                                                            |
// +-------------------------------------------------------------------------+
package sobel_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_FILL   = 2'd1;
  localparam state_t S_ACTIVE = 2'd2;

  // Gradient width: a 1-2-1 kernel sum needs two extra bits, plus a sign bit.
  function automatic int grad_w(input int pixw);
    return pixw + 3;
  endfunction

  function automatic logic [31:0] saturate(input logic [31:0] mag, input int pixw);
    logic [31:0] lim;
    lim = (32'd1 << pixw) - 32'd1;
    return (mag > lim) ? lim : mag;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sobel_line_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// +-------------------------------------------------------------------------+
// | sobel_line_buffer                                                        |
// | Simple-dual-port line RAM, synchronous read-before-write on one clock.   |
// | Revision: 1.0                                                            |
// +-------------------------------------------------------------------------+
module sobel_line_buffer #(
  parameter int PIXW      = 8,
  parameter int ADDRWIDTH = 12
) (
  input  logic                 clk,
  input  logic                 i_en,
  input  logic [ADDRWIDTH-1:0] i_raddr,
  output logic [PIXW-1:0]      o_rdata,
  input  logic                 i_we,
  input  logic [ADDRWIDTH-1:0] i_waddr,
  input  logic [PIXW-1:0]      i_wdata
);

  logic [PIXW-1:0] mem_q [2**ADDRWIDTH];
  logic [PIXW-1:0] rdata_q;

  // Same-address read and write in one cycle returns the old contents.
  always_ff @(posedge clk) begin
    if (i_en) begin
      rdata_q <= mem_q[i_raddr];
    end
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/sobel_stream_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// +-------------------------------------------------------------------------+
// | sobel_stream_pipe                                                        |
// | Streaming 3x3 Sobel |Gx|+|Gy| filter, AXI-Stream in/out, global stall.   |
// | Optional build macro SOBEL_THRESH_EN binarises the output.               |
// | Revision: 1.0                                                            |
// +-------------------------------------------------------------------------+
module sobel_stream_pipe
  import sobel_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int PIXW      = 8,
  parameter int ADDRWIDTH = 12
) (
  input  logic                 CLK,
  input  logic                 ARESETN,
  input  logic [DATAWIDTH-1:0] S_AXIS_TDATA,
  input  logic                 S_AXIS_TLAST,
  input  logic                 S_AXIS_TVALID,
  output logic                 S_AXIS_TREADY,
  output logic [DATAWIDTH-1:0] M_AXIS_TDATA,
  output logic                 M_AXIS_TLAST,
  output logic                 M_AXIS_TVALID,
  input  logic                 M_AXIS_TREADY,
  input  logic [ADDRWIDTH:0]   cfg_line_len,
  input  logic [PIXW-1:0]      cfg_thresh,
  output logic [15:0]          stat_frames,
  output logic                 stat_err
);

  localparam int                 GW      = grad_w(PIXW);
  localparam logic [PIXW-1:0]    PIX_MAX = '1;
  localparam logic [ADDRWIDTH:0] C_ONE   = (ADDRWIDTH+1)'(1);
  localparam logic [ADDRWIDTH:0] C_TWO   = (ADDRWIDTH+1)'(2);
  localparam logic [ADDRWIDTH:0] C_THREE = (ADDRWIDTH+1)'(3);
  localparam logic [ADDRWIDTH:0] MAX_LEN = {1'b1, {ADDRWIDTH{1'b0}}};

  state_t               state_q, state_d;
  logic [ADDRWIDTH:0]   col_q, col_d, len_q, len_d;
  logic [1:0]           row_q, row_d;
  logic                 bad_q, bad_d, err_q, err_d, rdy_q, rdy_d;
  logic [15:0]          frames_q, frames_d;

  logic                 s1_valid_q, s1_valid_d, s1_out_q, s1_out_d, s1_last_q, s1_last_d;
  logic [PIXW-1:0]      s1_pix_q, s1_pix_d;
  logic [ADDRWIDTH-1:0] s1_addr_q, s1_addr_d;
  logic                 s2_out_q, s2_out_d, s2_last_q, s2_last_d;
  logic [PIXW-1:0]      top_q [3], top_d [3], mid_q [3], mid_d [3], bot_q [3], bot_d [3];
  logic                 m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic [PIXW-1:0]      m_data_q, m_data_d;

  logic                 advance, s_ready, accept;
  logic [PIXW-1:0]      pix_in, lb0_rdata, lb1_rdata;
  logic [ADDRWIDTH:0]   cur_len;
  logic                 cur_bad, at_eol, produce;
  logic [GW-1:0]        sum_xp, sum_xn, sum_yp, sum_yn, gx, gy, ax, ay, mag;
  logic [PIXW-1:0]      sat_mag, res;
  logic                 unused_ok;

  assign advance       = !(m_valid_q && !M_AXIS_TREADY);
  assign s_ready       = rdy_q && advance;
  assign accept        = S_AXIS_TVALID && s_ready;
  assign pix_in        = S_AXIS_TDATA[PIXW-1:0];
  assign unused_ok     = ^{S_AXIS_TDATA, cfg_thresh};

  assign S_AXIS_TREADY = s_ready;
  assign M_AXIS_TDATA  = DATAWIDTH'(m_data_q);
  assign M_AXIS_TLAST  = m_last_q;
  assign M_AXIS_TVALID = m_valid_q;
  assign stat_frames   = frames_q;
  assign stat_err      = err_q;

  // Frame control: the first beat of a frame uses the live cfg_line_len.
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    len_d    = len_q;
    bad_d    = bad_q;
    err_d    = err_q;
    frames_d = frames_q;
    rdy_d    = 1'b1;
    cur_len  = len_q;
    cur_bad  = bad_q;
    if (state_q == S_IDLE) begin
      cur_len = cfg_line_len;
      cur_bad = (cfg_line_len < C_THREE) || (cfg_line_len > MAX_LEN);
    end
    at_eol  = (col_q == (cur_len - C_ONE));
    produce = 1'b0;
    if (accept) begin
      produce = (state_q == S_ACTIVE) && !cur_bad && (col_q >= C_TWO) &&
                !(S_AXIS_TLAST && !at_eol);
      len_d   = cur_len;
      bad_d   = cur_bad;
      if (cur_bad) begin
        err_d = 1'b1;
      end
      if (S_AXIS_TLAST) begin
        if (!at_eol || (row_q != 2'd2)) begin
          err_d = 1'b1;
        end
        state_d  = S_IDLE;
        col_d    = '0;
        row_d    = '0;
        frames_d = frames_q + 16'd1;
      end else begin
        if (at_eol) begin
          col_d = '0;
          if (row_q != 2'd2) begin
            row_d = row_q + 2'd1;
          end
        end else begin
          col_d = col_q + C_ONE;
        end
        state_d = (row_d == 2'd2) ? S_ACTIVE : S_FILL;
      end
    end
  end

  sobel_line_buffer #(.PIXW(PIXW), .ADDRWIDTH(ADDRWIDTH)) u_lb0 (
    .clk     (CLK),
    .i_en    (advance),
    .i_raddr (col_q[ADDRWIDTH-1:0]),
    .o_rdata (lb0_rdata),
    .i_we    (accept),
    .i_waddr (col_q[ADDRWIDTH-1:0]),
    .i_wdata (pix_in)
  );

  // lb1 is written one stage late, once lb0's displaced pixel has been read out.
  sobel_line_buffer #(.PIXW(PIXW), .ADDRWIDTH(ADDRWIDTH)) u_lb1 (
    .clk     (CLK),
    .i_en    (advance),
    .i_raddr (col_q[ADDRWIDTH-1:0]),
    .o_rdata (lb1_rdata),
    .i_we    (advance && s1_valid_q),
    .i_waddr (s1_addr_q),
    .i_wdata (lb0_rdata)
  );

  always_comb begin
    sum_xp  = GW'(top_q[2]) + (GW'(mid_q[2]) << 1) + GW'(bot_q[2]);
    sum_xn  = GW'(top_q[0]) + (GW'(mid_q[0]) << 1) + GW'(bot_q[0]);
    sum_yp  = GW'(bot_q[0]) + (GW'(bot_q[1]) << 1) + GW'(bot_q[2]);
    sum_yn  = GW'(top_q[0]) + (GW'(top_q[1]) << 1) + GW'(top_q[2]);
    gx      = sum_xp - sum_xn;
    gy      = sum_yp - sum_yn;
    ax      = gx[GW-1] ? -gx : gx;
    ay      = gy[GW-1] ? -gy : gy;
    mag     = ax + ay;
    sat_mag = PIXW'(saturate(32'(mag), PIXW));
`ifdef SOBEL_THRESH_EN
    res     = (sat_mag >= cfg_thresh) ? PIX_MAX : '0;
`else
    res     = sat_mag;
`endif
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_out_d   = s1_out_q;
    s1_last_d  = s1_last_q;
    s1_pix_d   = s1_pix_q;
    s1_addr_d  = s1_addr_q;
    s2_out_d   = s2_out_q;
    s2_last_d  = s2_last_q;
    top_d      = top_q;
    mid_d      = mid_q;
    bot_d      = bot_q;
    m_valid_d  = m_valid_q;
    m_last_d   = m_last_q;
    m_data_d   = m_data_q;
    if (advance) begin
      s1_valid_d = accept;
      s1_out_d   = produce;
      s1_last_d  = produce && S_AXIS_TLAST;
      s1_pix_d   = pix_in;
      s1_addr_d  = col_q[ADDRWIDTH-1:0];
      s2_out_d   = s1_valid_q && s1_out_q;
      s2_last_d  = s1_valid_q && s1_last_q;
      // Window columns only move on real pixels, so bubbles never split it.
      if (s1_valid_q) begin
        top_d[0] = top_q[1];  top_d[1] = top_q[2];  top_d[2] = lb1_rdata;
        mid_d[0] = mid_q[1];  mid_d[1] = mid_q[2];  mid_d[2] = lb0_rdata;
        bot_d[0] = bot_q[1];  bot_d[1] = bot_q[2];  bot_d[2] = s1_pix_q;
      end
      m_valid_d  = s2_out_q;
      m_last_d   = s2_last_q;
      m_data_d   = res;
    end
  end

  always_ff @(posedge CLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= S_IDLE;
      col_q      <= '0;
      row_q      <= '0;
      len_q      <= '0;
      bad_q      <= 1'b0;
      err_q      <= 1'b0;
      frames_q   <= '0;
      rdy_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_out_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_pix_q   <= '0;
      s1_addr_q  <= '0;
      s2_out_q   <= 1'b0;
      s2_last_q  <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        top_q[i] <= '0;
        mid_q[i] <= '0;
        bot_q[i] <= '0;
      end
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      m_data_q   <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      len_q      <= len_d;
      bad_q      <= bad_d;
      err_q      <= err_d;
      frames_q   <= frames_d;
      rdy_q      <= rdy_d;
      s1_valid_q <= s1_valid_d;
      s1_out_q   <= s1_out_d;
      s1_last_q  <= s1_last_d;
      s1_pix_q   <= s1_pix_d;
      s1_addr_q  <= s1_addr_d;
      s2_out_q   <= s2_out_d;
      s2_last_q  <= s2_last_d;
      top_q      <= top_d;
      mid_q      <= mid_d;
      bot_q      <= bot_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      m_data_q   <= m_data_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sobel_stream_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// Directed self-checking bench for sobel_stream_pipe (W=5/4 frames, stall, error, reset).
module tb_sobel_stream_pipe;

  localparam int DW = 32;
  localparam int PW = 8;
  localparam int AW = 12;

  logic          CLK = 1'b0;
  logic          ARESETN = 1'b0;
  logic [DW-1:0] S_TDATA;
  logic          S_TLAST, S_TVALID, S_TREADY;
  logic [DW-1:0] M_TDATA;
  logic          M_TLAST, M_VALID, M_READY;
  logic [AW:0]   cfg_line_len;
  logic [PW-1:0] cfg_thresh;
  logic [15:0]   stat_frames;
  logic          stat_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int acc22  = 0;
  int got_d[$];
  int got_l[$];
  int got_c[$];
  int ex[$];

  always #5 CLK = ~CLK;

  sobel_stream_pipe #(.DATAWIDTH(DW), .PIXW(PW), .ADDRWIDTH(AW)) dut (
    .CLK           (CLK),
    .ARESETN       (ARESETN),
    .S_AXIS_TDATA  (S_TDATA),
    .S_AXIS_TLAST  (S_TLAST),
    .S_AXIS_TVALID (S_TVALID),
    .S_AXIS_TREADY (S_TREADY),
    .M_AXIS_TDATA  (M_TDATA),
    .M_AXIS_TLAST  (M_TLAST),
    .M_AXIS_TVALID (M_VALID),
    .M_AXIS_TREADY (M_READY),
    .cfg_line_len  (cfg_line_len),
    .cfg_thresh    (cfg_thresh),
    .stat_frames   (stat_frames),
    .stat_err      (stat_err)
  );

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (ARESETN && M_VALID && M_READY) begin
      got_d.push_back(int'(M_TDATA));
      got_l.push_back(int'(M_TLAST));
      got_c.push_back(cyc);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int expv(input int sat);
`ifdef SOBEL_THRESH_EN
    return (sat >= 128) ? 255 : 0;
`else
    return sat;
`endif
  endfunction

  function automatic int pix(input int mode, input int c);
    if (mode == 0) return 100;
    if (mode == 1) return (c < 3) ? 0 : 200;
    return c * 10;
  endfunction

  task automatic send(input int p, input bit last, output int acc_c);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    acc_c = -1;
    S_TDATA = DW'(p);
    S_TLAST = last;
    S_TVALID = 1'b1;
    while (!acc && n < 50) begin
      @(negedge CLK);
      n++;
      acc = S_TREADY;
      acc_c = cyc;
      @(posedge CLK);
      #1;
    end
    S_TVALID = 1'b0;
    S_TLAST = 1'b0;
    chk("beat_accepted", 32'(acc), 1);
  endtask

  task automatic send_frame(input int w, input int nbeats, input int mode, input bit with_last);
    int ac;
    cfg_line_len = (AW+1)'(w);
    for (int k = 0; k < nbeats; k++) begin
      send(pix(mode, k % w), with_last && (k == nbeats - 1), ac);
      if (k == 2 * w + 2) acc22 = ac;
    end
  endtask

  task automatic drain_and_check(input string tag);
    repeat (8) @(posedge CLK);
    #1;
    chk({tag, "_count"}, got_d.size(), ex.size());
    for (int i = 0; i < ex.size() && i < got_d.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), got_d[i], expv(ex[i]));
      chk($sformatf("%s_last%0d", tag, i), got_l[i], (i == ex.size() - 1) ? 1 : 0);
    end
    got_d.delete();
    got_l.delete();
    got_c.delete();
  endtask

  initial begin
    S_TVALID = 1'b0;
    S_TDATA = '0;
    S_TLAST = 1'b0;
    M_READY = 1'b1;
    cfg_line_len = '0;
    cfg_thresh = 8'd128;

    repeat (3) @(negedge CLK);
    chk("rst_mvalid", 32'(M_VALID), 0);
    chk("rst_mdata", M_TDATA, 0);
    chk("rst_mlast", 32'(M_TLAST), 0);
    chk("rst_sready", 32'(S_TREADY), 0);
    chk("rst_frames", 32'(stat_frames), 0);
    chk("rst_err", 32'(stat_err), 0);
    ARESETN = 1'b1;
    @(posedge CLK);
    #1;
    chk("rel_sready", 32'(S_TREADY), 1);

    // Test 1: flat 5x4 frame
    send_frame(5, 20, 0, 1'b1);
    ex = '{0, 0, 0, 0, 0, 0};
    drain_and_check("t1");
    chk("t1_frames", 32'(stat_frames), 1);
    chk("t1_err", 32'(stat_err), 0);

    // Test 2: vertical step edge, saturating
    send_frame(5, 15, 1, 1'b1);
    ex = '{0, 255, 255};
    drain_and_check("t2");
    chk("t2_frames", 32'(stat_frames), 2);

    // Test 3: horizontal ramp, latency of first output
    send_frame(4, 12, 2, 1'b1);
    repeat (8) @(posedge CLK);
    #1;
    chk("t3_latency", (got_c.size() > 0) ? got_c[0] : -1, acc22 + 3);
    ex = '{80, 80};
    drain_and_check("t3");
    chk("t3_frames", 32'(stat_frames), 3);

    // Test 4: ramp with backpressure on the first output
    M_READY = 1'b0;
    fork
      send_frame(4, 12, 2, 1'b1);
      begin
        for (int n = 0; n < 100 && !M_VALID; n++) @(negedge CLK);
        for (int s = 0; s < 3; s++) begin
          chk("t4_hold_valid", 32'(M_VALID), 1);
          chk("t4_hold_data", M_TDATA, expv(80));
          chk("t4_hold_sready", 32'(S_TREADY), 0);
          if (s < 2) @(negedge CLK);
        end
        @(posedge CLK);
        #1;
        M_READY = 1'b1;
      end
    join
    ex = '{80, 80};
    drain_and_check("t4");
    chk("t4_frames", 32'(stat_frames), 4);
    chk("t4_err", 32'(stat_err), 0);

    // Test 5: early TLAST in row 1, then a good frame
    send_frame(5, 7, 0, 1'b1);
    ex.delete();
    drain_and_check("t5a");
    chk("t5_err", 32'(stat_err), 1);
    chk("t5_frames", 32'(stat_frames), 5);
    send_frame(5, 15, 1, 1'b1);
    ex = '{0, 255, 255};
    drain_and_check("t5b");
    chk("t5b_frames", 32'(stat_frames), 6);

    // Test 6: reset in the middle of row 2
    send_frame(5, 13, 0, 1'b0);
    ARESETN = 1'b0;
    #2;
    chk("t6_rst_mvalid", 32'(M_VALID), 0);
    chk("t6_rst_mdata", M_TDATA, 0);
    chk("t6_rst_mlast", 32'(M_TLAST), 0);
    chk("t6_rst_sready", 32'(S_TREADY), 0);
    chk("t6_rst_frames", 32'(stat_frames), 0);
    chk("t6_rst_err", 32'(stat_err), 0);
    repeat (2) @(negedge CLK);
    ARESETN = 1'b1;
    @(posedge CLK);
    #1;
    send_frame(5, 20, 0, 1'b1);
    ex = '{0, 0, 0, 0, 0, 0};
    drain_and_check("t6");
    chk("t6_frames", 32'(stat_frames), 1);
    chk("t6_err", 32'(stat_err), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
